tt_um_hamming_encoder_74: RTL and testbench

TT_UM_HAMMING_ENCODER_74 -- requirements
Module: tt_um_hamming_encoder_74

---
 rtl/hamming74_pkg.sv | 18 +
 rtl/hamming74_codeword_gen.sv | 21 ++
 rtl/tt_um_hamming_encoder_74.sv | 75 +++++++
 tb/tb_tt_um_hamming_encoder_74.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/hamming74_pkg.sv
// hamming74_pkg: Hamming(7,4) constants, FSM state type and parity rule shared by the encoder and decoder.
// Codeword vectors are in transmit order, so bit index = position - 1 (P1 is sent first).
package hamming74_pkg;
  localparam int CODEWORD_W = 7;
  localparam int DATA_W = 4;
  localparam int P1 = 0;
  localparam int P2 = 1;
  localparam int D0 = 2;
  localparam int P3 = 3;
  localparam int D1 = 4;
  localparam int D2 = 5;
  localparam int D3 = 6;
  typedef enum logic {IDLE, SEND} state_t;
  // Returns {p3, p2, p1}.
  function automatic logic [2:0] parity(input logic [DATA_W-1:0] d);
    return {d[1] ^ d[2] ^ d[3], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]};
  endfunction
endpackage

// File: rtl/hamming74_codeword_gen.sv
// hamming74_codeword_gen: combinational nibble -> 7-bit Hamming codeword in transmit order.
// Ports: data [3:0] nibble d3..d0; codeword [6:0] with bit 0 = position 1.
module hamming74_codeword_gen
  import hamming74_pkg::*;
(
  input  logic [DATA_W-1:0]     data,
  output logic [CODEWORD_W-1:0] codeword
);
  logic [2:0] p;
  always_comb begin
    p = parity(data);
    codeword = '0;
    codeword[P1] = p[0];
    codeword[P2] = p[1];
    codeword[D0] = data[0];
    codeword[P3] = p[2];
    codeword[D1] = data[1];
    codeword[D2] = data[2];
    codeword[D3] = data[3];
  end
endmodule

// File: rtl/tt_um_hamming_encoder_74.sv
// tt_um_hamming_encoder_74: serial Hamming(7,4) encoder, one codeword bit per enabled cycle.
// Ports: clk, rst_n (async active-low), ena (hold when low), data_in [3:0], data_valid,
//        data_ready, encode_out, frame_active, frame_start; err_inj [2:0] only with HAMMING_ERR_INJECT_EN.
// Optional macro HAMMING_ERR_INJECT_EN: err_inj != 0 at accept inverts that codeword position.
module tt_um_hamming_encoder_74
  import hamming74_pkg::*;
#(
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
`ifdef HAMMING_ERR_INJECT_EN
  input  logic [2:0]        err_inj,
`endif
  output logic              data_ready,
  output logic              encode_out,
  output logic              frame_active,
  output logic              frame_start
);
  state_t state, state_n;
  logic [2:0] cnt;
  logic [CODEWORD_W-1:0] sr, cw, cw_tx;
  logic last, accept;

  hamming74_codeword_gen u_gen (.data(data_in), .codeword(cw));

`ifdef HAMMING_ERR_INJECT_EN
  assign cw_tx = (err_inj != 3'd0) ? cw ^ (CODEWORD_W'(1) << (err_inj - 3'd1)) : cw;
`else
  assign cw_tx = cw;
`endif

  // Ready in the last bit cycle lets the next frame follow with no gap.
  assign last = (state == SEND) && (cnt == 3'd6);
  assign data_ready = (state == IDLE) || last;
  assign accept = ena && data_valid && data_ready;

  always_comb begin
    state_n = state;
    if (ena) state_n = accept ? SEND : last ? IDLE : state;
  end

  // encode_out is registered separately from sr so it can hold IDLE_LEVEL between frames.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      sr <= '0;
      encode_out <= IDLE_LEVEL;
      frame_active <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      state <= state_n;
      frame_start <= accept;
      if (accept) begin
        sr <= cw_tx;
        encode_out <= cw_tx[0];
        cnt <= '0;
        frame_active <= 1'b1;
      end else if (ena && last) begin
        sr <= '0;
        encode_out <= IDLE_LEVEL;
        cnt <= '0;
        frame_active <= 1'b0;
      end else if (ena && state == SEND) begin
        sr <= sr >> 1;
        encode_out <= sr[1];
        cnt <= cnt + 3'd1;
      end
    end
  end
endmodule

// File: tb/tb_tt_um_hamming_encoder_74.sv
// tb_tt_um_hamming_encoder_74: directed and random checks of the serial Hamming(7,4) encoder.
module tb_tt_um_hamming_encoder_74;
  logic clk = 1'b0;
  logic rst_n, ena, data_valid;
  logic [3:0] data_in;
  logic data_ready, encode_out, frame_active, frame_start;
  int n_cmp = 0;
  int n_err = 0;
  logic [3:0] d;
  logic [6:0] exp_cw, rx;
  int e;
`ifdef HAMMING_ERR_INJECT_EN
  logic [2:0] err_inj;
`endif

  always #5 clk = ~clk;

  tt_um_hamming_encoder_74 dut (
    .clk(clk),
    .rst_n(rst_n),
    .ena(ena),
    .data_in(data_in),
    .data_valid(data_valid),
`ifdef HAMMING_ERR_INJECT_EN
    .err_inj(err_inj),
`endif
    .data_ready(data_ready),
    .encode_out(encode_out),
    .frame_active(frame_active),
    .frame_start(frame_start)
  );

  // Reference codeword from the textbook rule: data at non-power-of-two positions,
  // parity bit k covers every position whose index has bit k set. Bit 0 = position 1.
  function automatic logic [6:0] model(input logic [3:0] dd, input int err);
    logic [7:1] c;
    c = '0;
    c[3] = dd[0];
    c[5] = dd[1];
    c[6] = dd[2];
    c[7] = dd[3];
    for (int k = 1; k <= 4; k = k * 2)
      for (int pos = 3; pos <= 7; pos++)
        if ((pos & k) != 0 && pos != k) c[k] = c[k] ^ c[pos];
    if (err != 0) c[err] = ~c[err];
    return c[7:1];
  endfunction

  function automatic logic [3:0] decode(input logic [6:0] cw);
    logic [7:1] c;
    int s;
    c = cw;
    s = 0;
    for (int pos = 1; pos <= 7; pos++) if (c[pos]) s = s ^ pos;
    if (s != 0) c[s] = ~c[s];
    return {c[7], c[6], c[5], c[3]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called in the bit-1 cycle; returns in the bit-7 cycle.
  task automatic run_bits(input string tag, input logic [6:0] cw);
    for (int i = 0; i < 7; i++) begin
      if (i > 0) tick();
      chk({tag, "_bit"}, encode_out, cw[i]);
      chk({tag, "_fs"}, frame_start, i == 0);
      chk({tag, "_fa"}, frame_active, 1);
      chk({tag, "_rdy"}, data_ready, i == 6);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_idle_fa"}, frame_active, 0);
    chk({tag, "_idle_eo"}, encode_out, 0);
    chk({tag, "_idle_fs"}, frame_start, 0);
    chk({tag, "_idle_rdy"}, data_ready, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    ena = 1'b1;
    data_valid = 1'b0;
    data_in = 4'h0;
`ifdef HAMMING_ERR_INJECT_EN
    err_inj = 3'd0;
`endif
    repeat (2) tick();
    chk_idle("reset");
    rst_n = 1'b1;
    tick();
    chk("post_reset_rdy", data_ready, 1);

    data_in = 4'b1011;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    data_in = 4'($urandom);
    run_bits("f1011", 7'b1010101);
    tick();
    chk_idle("f1011");

    data_in = 4'h0;
    data_valid = 1'b1;
    tick();
    data_in = 4'hF;
    run_bits("b2b0", 7'b0000000);
    tick();
    run_bits("b2bF", 7'b1111111);
    data_valid = 1'b0;
    tick();
    chk_idle("b2b");

    data_in = 4'b1011;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    chk("stall_b1", encode_out, 1);
    tick();
    chk("stall_b2", encode_out, 0);
    ena = 1'b0;
    repeat (3) begin
      tick();
      chk("stall_eo", encode_out, 0);
      chk("stall_fa", frame_active, 1);
      chk("stall_fs", frame_start, 0);
      chk("stall_rdy", data_ready, 0);
    end
    ena = 1'b1;
    for (int i = 2; i < 7; i++) begin
      tick();
      chk("stall_resume", encode_out, (7'b1010101 >> i) & 7'd1);
    end
    tick();
    chk_idle("stall");

    d = 4'($urandom);
    data_in = d;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk_idle("midreset");
    tick();
    rst_n = 1'b1;
    repeat (8) begin
      tick();
      chk("after_reset_fa", frame_active, 0);
      chk("after_reset_eo", encode_out, 0);
    end
    d = 4'($urandom);
    data_in = d;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    run_bits("post_reset_frame", model(d, 0));
    tick();
    chk_idle("post_reset_frame");

`ifdef HAMMING_ERR_INJECT_EN
    data_in = 4'h0;
    err_inj = 3'd3;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    err_inj = 3'd0;
    rx = '0;
    for (int i = 0; i < 7; i++) begin
      if (i > 0) tick();
      rx[i] = encode_out;
    end
    chk("inj_cw", rx, 7'b0000100);
    chk("inj_dec", decode(rx), 4'h0);
    tick();
`endif

    for (int f = 0; f < 1000; f++) begin
      d = 4'($urandom);
      e = 0;
      data_in = d;
`ifdef HAMMING_ERR_INJECT_EN
      e = $urandom_range(0, 7);
      err_inj = 3'(e);
`endif
      data_valid = 1'b1;
      tick();
      data_valid = 1'b0;
      data_in = 4'($urandom);
`ifdef HAMMING_ERR_INJECT_EN
      err_inj = 3'($urandom);
`endif
      exp_cw = model(d, e);
      for (int i = 0; i < 7; i++) begin
        if (i > 0) tick();
        rx[i] = encode_out;
        chk("rnd_fs", frame_start, i == 0);
        if (i < 6 && $urandom_range(0, 3) == 0) begin
          ena = 1'b0;
          tick();
          chk("rnd_hold_eo", encode_out, rx[i]);
          chk("rnd_hold_fs", frame_start, 0);
          ena = 1'b1;
        end
      end
      chk("rnd_cw", rx, exp_cw);
      chk("rnd_dec", decode(rx), d);
      if ($urandom_range(0, 1) == 1) begin
        tick();
        chk("rnd_idle", frame_active, 0);
      end
    end
    tick();
    chk("final_idle", frame_active, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
